// File: rtl/noc_vc_scheduler.sv
// Packet-atomic round-robin scheduler: several virtual-channel packet sources
// share one physical NoC output link. A granted VC owns the link until its
// last flit has been accepted. The output flit, last marker and valid are held
// in a single output register.
//
// Handshake semantics (all ports): a beat moves on a rising clk edge where
// valid and ready are both high for the same VC. valid never depends on
// ready. in_ready is one-hot on the granted VC or zero. out_valid is one-hot on
// the VC of the held flit or zero.
`timescale 1ns/1ps

module noc_vc_scheduler #(
  parameter int FLIT_WIDTH = 34,
  parameter int VCHANNELS  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [VCHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]            in_last,
  input  logic [VCHANNELS-1:0]            in_valid,
  output logic [VCHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic                            out_last,
  output logic [VCHANNELS-1:0]            out_valid,
  input  logic [VCHANNELS-1:0]            out_ready
);

  localparam int GW = $clog2(VCHANNELS);
  localparam logic [GW:0]   NUM_VC  = (GW+1)'(VCHANNELS);
  localparam logic [GW-1:0] LAST_VC = GW'(VCHANNELS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [GW-1:0]          grant;
  logic [GW-1:0]          rr_ptr;
  logic [GW-1:0]          pick;
  logic [GW-1:0]          pick_off;
  logic [GW:0]            pick_sum;
  logic [GW-1:0]          grant_inc;
  logic [VCHANNELS-1:0]   rot_valid;
  logic [VCHANNELS-1:0]   grant_onehot;
  logic [FLIT_WIDTH-1:0]  sel_flit;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   any_valid;
  logic                   drain;
  logic                   reg_free;
  logic                   xfer;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back into a VC index.
  always_comb begin
    rot_valid = VCHANNELS'({in_valid, in_valid} >> rr_ptr);
    pick_off  = '0;
    for (int i = VCHANNELS - 1; i >= 0; i--) begin
      if (rot_valid[i]) pick_off = GW'(i);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    pick     = (pick_sum >= NUM_VC) ? GW'(pick_sum - NUM_VC) : GW'(pick_sum);
  end

  // Select the granted VC's input beat and derive the handshake terms.
  always_comb begin
    grant_onehot = VCHANNELS'(1) << grant;
    sel_flit     = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      if (grant_onehot[v]) sel_flit = in_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
    end
    sel_valid = |(in_valid & grant_onehot);
    sel_last  = |(in_last & grant_onehot);
    any_valid = |in_valid;
    drain     = |(out_valid & out_ready);
    reg_free  = ~|out_valid | drain;
    xfer      = (state == ACTIVE) && reg_free && sel_valid;
    in_ready  = ((state == ACTIVE) && reg_free) ? grant_onehot : '0;
    grant_inc = (grant == LAST_VC) ? '0 : grant + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state: one arbitration cycle, then hold until the last flit moves.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = ACTIVE;
      ACTIVE:  if (xfer && sel_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant capture in IDLE and pointer advance after a packet's last flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && any_valid) grant <= pick;
      if (xfer && sel_last) rr_ptr <= grant_inc;
    end
  end

  // Output register: load on input transfer, clear valid when drained empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= '0;
    end else if (xfer) begin
      out_flit  <= sel_flit;
      out_last  <= sel_last;
      out_valid <= grant_onehot;
    end else if (drain) begin
      out_valid <= '0;
    end
  end

endmodule

// File: tb/tb_noc_vc_scheduler.sv
// Bench for noc_vc_scheduler: directed scenarios followed by random traffic,
// checked against a transaction-level reference model and a flit scoreboard.
`timescale 1ns/1ps

module tb_noc_vc_scheduler;

  localparam int FW  = 34;
  localparam int NV  = 3;
  localparam int SBW = 2 + 1 + FW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NV*FW-1:0] in_flit;
  logic [NV-1:0]    in_last;
  logic [NV-1:0]    in_valid;
  logic [NV-1:0]    in_ready;
  logic [FW-1:0]    out_flit;
  logic             out_last;
  logic [NV-1:0]    out_valid;
  logic [NV-1:0]    out_ready;

  noc_vc_scheduler #(.FLIT_WIDTH(FW), .VCHANNELS(NV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // sources: per-VC queue of {last, flit}; en gates in_valid, ordy drives out_ready
  logic [FW:0]   src_q [NV][$];
  logic [NV-1:0] en;
  logic [NV-1:0] ordy;

  // scoreboard: {vc, last, flit} in link order
  logic [SBW-1:0] exp_q [$];
  int             obs_starts [$];
  bit             start_flag;
  int             n_out;

  // reference model: who owns the link, where the search starts, what is held
  bit             m_active;
  int             m_grant;
  int             m_ptr;
  int             m_ov;
  logic [FW-1:0]  m_flit;
  logic           m_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int vc_of(input logic [NV-1:0] oh);
    int r;
    r = -1;
    for (int v = NV - 1; v >= 0; v--) if (oh[v]) r = v;
    return r;
  endfunction

  task automatic add_pkt(input int v, input int len);
    logic [FW-1:0] f;
    for (int i = 0; i < len; i++) begin
      f = {$urandom(), 2'(v)};
      src_q[v].push_back({(i == len - 1), f});
    end
  endtask

  task automatic drive_inputs();
    logic [FW:0] e;
    for (int v = 0; v < NV; v++) begin
      if (en[v] && src_q[v].size() > 0) begin
        e = src_q[v][0];
        in_valid[v] = 1'b1;
        in_last[v]  = e[FW];
        in_flit[v*FW +: FW] = e[FW-1:0];
      end else begin
        in_valid[v] = 1'b0;
        in_last[v]  = 1'b0;
        in_flit[v*FW +: FW] = '0;
      end
    end
    out_ready = ordy;
  endtask

  task automatic reset_model();
    m_active = 1'b0;
    m_grant  = 0;
    m_ptr    = 0;
    m_ov     = -1;
    m_flit   = '0;
    m_last   = 1'b0;
    exp_q.delete();
    for (int v = 0; v < NV; v++) src_q[v].delete();
    start_flag = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, '0);
    chk({tag, "_out_valid"}, out_valid, '0);
    chk({tag, "_out_flit"}, out_flit, '0);
    chk({tag, "_out_last"}, out_last, 1'b0);
  endtask

  // one cycle of comparison plus model advance, evaluated mid-cycle
  task automatic check_cycle();
    logic          drain_m, free_m, xfer_m;
    logic [NV-1:0] exp_ir, exp_ov;
    logic [SBW-1:0] s;
    logic [FW:0]   e;
    int            idx;
    bit            found;
    drain_m = (m_ov >= 0) && out_ready[m_ov];
    free_m  = (m_ov < 0) || drain_m;
    exp_ir  = (m_active && free_m) ? NV'(1) << m_grant : '0;
    exp_ov  = (m_ov >= 0) ? NV'(1) << m_ov : '0;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (m_ov >= 0) begin
      chk("out_flit", out_flit, m_flit);
      chk("out_last", out_last, m_last);
    end
    if (|(out_valid & out_ready)) begin
      chk("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("sb_flit", {2'(vc_of(out_valid)), out_last, out_flit}, s);
      end
      if (start_flag) obs_starts.push_back(vc_of(out_valid));
      start_flag = out_last;
      n_out++;
    end
    xfer_m = 1'b0;
    if (!m_active) begin
      found = 1'b0;
      for (int i = 0; i < NV; i++) begin
        idx = (m_ptr + i) % NV;
        if (!found && in_valid[idx]) begin
          m_grant = idx;
          found   = 1'b1;
        end
      end
      if (found) m_active = 1'b1;
    end else if (free_m && in_valid[m_grant]) begin
      e      = src_q[m_grant].pop_front();
      m_ov   = m_grant;
      m_flit = e[FW-1:0];
      m_last = e[FW];
      exp_q.push_back({2'(m_grant), e});
      xfer_m = 1'b1;
      if (e[FW]) begin
        m_active = 1'b0;
        m_ptr    = (m_grant + 1) % NV;
      end
    end
    if (!xfer_m && drain_m) m_ov = -1;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  function automatic bit busy();
    bit b;
    b = m_active || (m_ov >= 0) || (exp_q.size() > 0);
    for (int v = 0; v < NV; v++) if (src_q[v].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain_all(input int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < max_cycles, 1'b1);
  endtask

  task automatic chk_starts(input string tag, input int e0, input int e1, input int e2,
                            input int cnt);
    int exp_s [3];
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2;
    chk({tag, "_count"}, obs_starts.size(), cnt);
    for (int i = 0; i < cnt && i < 3; i++)
      if (i < obs_starts.size()) chk({tag, "_order"}, obs_starts[i], exp_s[i]);
  endtask

  logic [FW-1:0] held_flit;

  initial begin
    en   = '1;
    ordy = '1;
    reset_model();
    n_out = 0;
    drive_inputs();

    // reset held with every VC requesting; first grant goes to VC0
    add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1);
    drive_inputs();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_starts.delete();
    drain_all(50);
    chk_starts("t1_grant", 0, 1, 2, 3);

    // all VCs with back-to-back 2-flit packets: strict 0,1,2,0,1,2
    obs_starts.delete();
    for (int r = 0; r < 2; r++) for (int v = 0; v < NV; v++) add_pkt(v, 2);
    drive_inputs();
    drain_all(100);
    chk("t3_count", obs_starts.size(), 6);
    for (int i = 0; i < 6 && i < obs_starts.size(); i++)
      chk("t3_order", obs_starts[i], i % NV);

    // single VC1 4-flit packet, exact cycle profile
    add_pkt(1, 4);
    drive_inputs();
    step();
    #1 chk("t2_in_ready_c2", in_ready, 3'b010);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("t2_out_valid", out_valid, 3'b010);
      chk("t2_out_last", out_last, (i == 3));
    end
    step();
    #1;
    chk("t2_out_valid_end", out_valid, 3'b000);
    chk("t2_in_ready_end", in_ready, 3'b000);
    drain_all(20);

    // VC0 stalls mid-packet while VC2 waits: VC2 must not be granted
    obs_starts.delete();
    add_pkt(0, 4);
    drive_inputs();
    step();
    add_pkt(2, 2);
    drive_inputs();
    step();
    step();
    en = 3'b110;
    drive_inputs();
    repeat (3) begin
      step();
      #1 chk("t4_vc2_blocked", in_ready[2], 1'b0);
    end
    en = '1;
    drive_inputs();
    drain_all(50);
    chk_starts("t4_order", 0, 2, 0, 2);

    // VC1 backpressured for 5 cycles: output held, nothing lost or repeated
    n_out = 0;
    add_pkt(1, 6);
    drive_inputs();
    step(); step(); step();
    ordy = 3'b101;
    drive_inputs();
    held_flit = out_flit;
    repeat (5) begin
      step();
      #1;
      chk("t5_flit_stable", out_flit, held_flit);
      chk("t5_in_ready", in_ready[1], 1'b0);
      chk("t5_out_valid", out_valid, 3'b010);
    end
    ordy = '1;
    drive_inputs();
    drain_all(50);
    chk("t5_flits_out", n_out, 6);

    // reset mid-packet after two flits; arbitration restarts at VC0
    add_pkt(2, 4);
    drive_inputs();
    step(); step(); step();
    rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    reset_model();
    drive_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_starts.delete();
    add_pkt(2, 2);
    add_pkt(0, 2);
    drive_inputs();
    drain_all(50);
    chk_starts("t6_restart", 0, 2, 0, 2);

    // random traffic, random source gaps and router backpressure
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int v;
        v = $urandom_range(0, NV - 1);
        if (src_q[v].size() < 12) add_pkt(v, $urandom_range(1, 5));
      end
      en   = NV'($urandom);
      ordy = NV'($urandom);
      drive_inputs();
      step();
    end
    en   = '1;
    ordy = '1;
    drive_inputs();
    drain_all(1000);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
